masked_argmax_stream: RTL and testbench

//  Serial masked-max reducer. Accepts one masked candidate per cycle over a frame and keeps a running maximum.

---
 rtl/masked_argmax_stream.sv | 138 +++++++++++++
 tb/tb_masked_argmax_stream.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/masked_argmax_stream.sv
// masked_argmax_stream: serial masked-max reducer over a framed candidate stream.
// Tracks the running maximum of masked beats, its beat index and the count of
// masked beats, then presents the frame result on a valid/ready output port.
// Optional build macro: MASKED_ARGMAX_TIE_LAST_EN -- when defined, equal values
// replace the held maximum, so the latest index wins a tie; when undefined the
// compare is strict and the earliest index wins.
module masked_argmax_stream #(
  parameter int WIDTH = 16,
  parameter int IDXW  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_mask,
  input  logic              in_last,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WIDTH-1:0]  out_max,
  output logic [IDXW-1:0]   out_idx,
  output logic [IDXW:0]     out_cnt,
  output logic              out_any,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t            r_state;
  logic [WIDTH-1:0]  r_max_acc;
  logic [IDXW-1:0]   r_idx_acc;
  logic [IDXW:0]     r_cnt_acc;
  logic              r_any_acc;
  logic [IDXW-1:0]   r_k;
  logic              r_busy;
  logic [WIDTH-1:0]  r_out_max;
  logic [IDXW-1:0]   r_out_idx;
  logic [IDXW:0]     r_out_cnt;
  logic              r_out_any;
  logic              r_out_valid;

  logic              w_accept;
  logic              w_better;
  logic              w_take;
  logic              w_cnt_sat;
  logic              w_out_fire;

  // Input is only accepted while accumulating; decoded straight from the state register.
  assign in_ready   = (r_state == S_ACC);
  assign w_accept   = in_valid & in_ready;
  assign w_out_fire = r_out_valid & out_ready;
  assign w_cnt_sat  = &r_cnt_acc;

`ifdef MASKED_ARGMAX_TIE_LAST_EN
  assign w_better = (in_data >= r_max_acc);
`else
  assign w_better = (in_data > r_max_acc);
`endif

  // The first masked beat always wins because the held maximum is not yet meaningful.
  assign w_take = in_mask & (~r_any_acc | w_better);

  // Frame FSM: accumulate beats, snapshot the result one cycle after the last beat, then hold until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_max_acc   <= '0;
      r_idx_acc   <= '0;
      r_cnt_acc   <= '0;
      r_any_acc   <= 1'b0;
      r_k         <= '0;
      r_busy      <= 1'b0;
      r_out_max   <= '0;
      r_out_idx   <= '0;
      r_out_cnt   <= '0;
      r_out_any   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_ACC;
        end
        S_ACC: begin
          if (w_accept) begin
            r_busy <= 1'b1;
            r_k    <= r_k + 1'b1;
            if (w_take) begin
              r_max_acc <= in_data;
              r_idx_acc <= r_k;
            end
            if (in_mask) begin
              r_any_acc <= 1'b1;
              if (!w_cnt_sat) begin
                r_cnt_acc <= r_cnt_acc + 1'b1;
              end
            end
            if (in_last) begin
              r_state <= S_OUT;
            end
          end
        end
        S_OUT: begin
          if (!r_out_valid) begin
            r_out_max   <= r_max_acc;
            r_out_idx   <= r_idx_acc;
            r_out_cnt   <= r_cnt_acc;
            r_out_any   <= r_any_acc;
            r_out_valid <= 1'b1;
          end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
            r_max_acc   <= '0;
            r_idx_acc   <= '0;
            r_cnt_acc   <= '0;
            r_any_acc   <= 1'b0;
            r_k         <= '0;
            r_busy      <= 1'b0;
            r_state     <= S_ACC;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign out_max   = r_out_max;
  assign out_idx   = r_out_idx;
  assign out_cnt   = r_out_cnt;
  assign out_any   = r_out_any;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;

endmodule

// File: tb/tb_masked_argmax_stream.sv
// Directed testbench for masked_argmax_stream.
// Honours MASKED_ARGMAX_TIE_LAST_EN for the expected tie-break index.
module tb_masked_argmax_stream;

  localparam int W  = 16;
  localparam int IW = 8;

`ifdef MASKED_ARGMAX_TIE_LAST_EN
  localparam bit TIE_LAST = 1'b1;
`else
  localparam bit TIE_LAST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  in_data;
  logic          in_mask;
  logic          in_last;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  out_max;
  logic [IW-1:0] out_idx;
  logic [IW:0]   out_cnt;
  logic          out_any;
  logic          out_valid;
  logic          out_ready;
  logic          busy;

  int total = 0;
  int bad   = 0;

  masked_argmax_stream #(.WIDTH(W), .IDXW(IW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_mask   (in_mask),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_max   (out_max),
    .out_idx   (out_idx),
    .out_cnt   (out_cnt),
    .out_any   (out_any),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat and hold it until accepted (bounded); ok=0 if never accepted.
  task automatic send_beat(input logic [W-1:0] d, input logic m, input logic l, output bit ok);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_mask  = m;
    in_last  = l;
    while (in_ready !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    ok = (in_ready === 1'b1);
    step();
    in_valid = 1'b0;
    in_mask  = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  // Wait (bounded) for out_valid.
  task automatic wait_valid(output bit ok);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    ok = (out_valid === 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 0; in_data = 0; in_mask = 0; in_last = 0; out_ready = 1'b1;
    #23;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%0b want=0", out_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_in_ready got=%0b want=0", in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%0b want=0", busy); end
    total++; if (out_max !== '0 || out_cnt !== '0 || out_idx !== '0 || out_any !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_outputs got max=%0d idx=%0d cnt=%0d any=%0b want all 0", out_max, out_idx, out_cnt, out_any);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL idle_in_ready got=%0b want=0", in_ready); end
    step();
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL acc_in_ready got=%0b want=1", in_ready); end
  endtask

  task automatic test_basic_frame();
    logic [W-1:0] d [4] = '{16'd5, 16'd9, 16'd3, 16'd9};
    bit ok, allok;
    logic [IW-1:0] want_idx;
    want_idx = TIE_LAST ? 8'd3 : 8'd1;
    allok = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_beat(d[i], 1'b1, (i == 3), ok);
      allok &= ok;
      if (i == 0) begin
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL basic_busy_set got=%0b want=1", busy); end
      end
    end
    total++; if (!allok) begin bad++; $display("[TB] FAIL basic_accept got=0 want=1"); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL basic_latency got=%0b want=0", out_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL basic_ready_after_last got=%0b want=0", in_ready); end
    step();
    total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL basic_valid got=%0b want=1", out_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL basic_ready_in_out got=%0b want=0", in_ready); end
    total++; if (out_max !== 16'd9) begin bad++; $display("[TB] FAIL basic_max got=%0d want=9", out_max); end
    total++; if (out_idx !== want_idx) begin bad++; $display("[TB] FAIL basic_idx got=%0d want=%0d", out_idx, want_idx); end
    total++; if (out_cnt !== 9'd4) begin bad++; $display("[TB] FAIL basic_cnt got=%0d want=4", out_cnt); end
    total++; if (out_any !== 1'b1) begin bad++; $display("[TB] FAIL basic_any got=%0b want=1", out_any); end
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL basic_busy_hold got=%0b want=1", busy); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL basic_valid_clear got=%0b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL basic_ready_back got=%0b want=1", in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL basic_busy_clear got=%0b want=0", busy); end
  endtask

  task automatic test_mask_skip();
    logic [W-1:0] d [4] = '{16'hFFFF, 16'd2, 16'd7, 16'd1};
    logic         m [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    bit ok, allok;
    allok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_beat(d[i], m[i], (i == 3), ok);
      allok &= ok;
    end
    wait_valid(ok);
    total++; if (!(allok && ok)) begin bad++; $display("[TB] FAIL mask_timeout got=0 want=1"); end
    total++; if (out_max !== 16'd2) begin bad++; $display("[TB] FAIL mask_max got=%0d want=2", out_max); end
    total++; if (out_idx !== 8'd1) begin bad++; $display("[TB] FAIL mask_idx got=%0d want=1", out_idx); end
    total++; if (out_cnt !== 9'd2) begin bad++; $display("[TB] FAIL mask_cnt got=%0d want=2", out_cnt); end
    total++; if (out_any !== 1'b1) begin bad++; $display("[TB] FAIL mask_any got=%0b want=1", out_any); end
    step();
  endtask

  task automatic test_all_unmasked();
    bit ok, allok;
    allok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_beat(16'd100 + 16'(i), 1'b0, (i == 2), ok);
      allok &= ok;
    end
    wait_valid(ok);
    total++; if (!(allok && ok)) begin bad++; $display("[TB] FAIL unmasked_timeout got=0 want=1"); end
    total++; if (out_any !== 1'b0 || out_max !== '0 || out_idx !== '0 || out_cnt !== '0) begin
      bad++; $display("[TB] FAIL unmasked_result got any=%0b max=%0d idx=%0d cnt=%0d want all 0", out_any, out_max, out_idx, out_cnt);
    end
    step();
  endtask

  task automatic test_backpressure();
    bit ok, allok;
    allok = 1'b1;
    out_ready = 1'b0;
    send_beat(16'd3, 1'b1, 1'b0, ok); allok &= ok;
    send_beat(16'd8, 1'b1, 1'b1, ok); allok &= ok;
    wait_valid(ok);
    total++; if (!(allok && ok)) begin bad++; $display("[TB] FAIL stall_timeout got=0 want=1"); end
    in_valid = 1'b1; in_data = 16'd100; in_mask = 1'b1; in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      total++; if (out_valid !== 1'b1 || out_max !== 16'd8 || out_idx !== 8'd1 || out_cnt !== 9'd2 || out_any !== 1'b1) begin
        bad++; $display("[TB] FAIL stall_hold cyc=%0d got v=%0b max=%0d idx=%0d cnt=%0d want v=1 max=8 idx=1 cnt=2", c, out_valid, out_max, out_idx, out_cnt);
      end
      total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL stall_in_ready cyc=%0d got=%0b want=0", c, in_ready); end
    end
    in_valid = 1'b0; in_mask = 1'b0; in_last = 1'b0; in_data = '0;
    out_ready = 1'b1;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL stall_release got=%0b want=0", out_valid); end
    send_beat(16'd7, 1'b1, 1'b0, ok); allok = ok;
    send_beat(16'd2, 1'b1, 1'b1, ok); allok &= ok;
    wait_valid(ok);
    total++; if (!(allok && ok)) begin bad++; $display("[TB] FAIL next_timeout got=0 want=1"); end
    total++; if (out_max !== 16'd7 || out_idx !== 8'd0 || out_cnt !== 9'd2) begin
      bad++; $display("[TB] FAIL next_frame got max=%0d idx=%0d cnt=%0d want max=7 idx=0 cnt=2", out_max, out_idx, out_cnt);
    end
    step();
  endtask

  task automatic test_back_to_back();
    bit ok, allok;
    logic [IW-1:0] want_idx;
    want_idx = TIE_LAST ? 8'd1 : 8'd0;
    send_beat(16'd9, 1'b1, 1'b0, ok); allok = ok;
    send_beat(16'd9, 1'b1, 1'b1, ok); allok &= ok;
    wait_valid(ok);
    total++; if (!(allok && ok)) begin bad++; $display("[TB] FAIL tie_timeout got=0 want=1"); end
    total++; if (out_idx !== want_idx || out_max !== 16'd9) begin
      bad++; $display("[TB] FAIL tie_idx got idx=%0d max=%0d want idx=%0d max=9", out_idx, out_max, want_idx);
    end
    step();
    send_beat(16'd55, 1'b0, 1'b1, ok);
    wait_valid(allok);
    total++; if (!(allok && ok)) begin bad++; $display("[TB] FAIL single_timeout got=0 want=1"); end
    total++; if (out_any !== 1'b0 || out_max !== '0 || out_idx !== '0 || out_cnt !== '0) begin
      bad++; $display("[TB] FAIL single_unmasked got any=%0b max=%0d idx=%0d cnt=%0d want all 0", out_any, out_max, out_idx, out_cnt);
    end
    step();
  endtask

  task automatic test_saturate_wrap();
    bit ok, allok;
    allok = 1'b1;
    for (int k = 0; k < 520; k++) begin
      send_beat((k == 258) ? 16'd1000 : 16'd5, 1'b1, (k == 519), ok);
      allok &= ok;
    end
    wait_valid(ok);
    total++; if (!(allok && ok)) begin bad++; $display("[TB] FAIL sat_timeout got=0 want=1"); end
    total++; if (out_cnt !== 9'd511) begin bad++; $display("[TB] FAIL sat_cnt got=%0d want=511", out_cnt); end
    total++; if (out_max !== 16'd1000 || out_idx !== 8'd2) begin
      bad++; $display("[TB] FAIL wrap_idx got max=%0d idx=%0d want max=1000 idx=2", out_max, out_idx);
    end
    step();
  endtask

  task automatic test_async_reset();
    bit ok, allok;
    send_beat(16'd10, 1'b1, 1'b0, ok); allok = ok;
    send_beat(16'd20, 1'b1, 1'b0, ok); allok &= ok;
    total++; if (busy !== 1'b1 || !allok) begin bad++; $display("[TB] FAIL areset_pre_busy got=%0b want=1", busy); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || out_cnt !== '0) begin
      bad++; $display("[TB] FAIL areset_clear got busy=%0b rdy=%0b v=%0b cnt=%0d want all 0", busy, in_ready, out_valid, out_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    send_beat(16'd4, 1'b1, 1'b1, ok);
    wait_valid(allok);
    total++; if (!(allok && ok)) begin bad++; $display("[TB] FAIL areset_timeout got=0 want=1"); end
    total++; if (out_max !== 16'd4 || out_idx !== 8'd0 || out_cnt !== 9'd1 || out_any !== 1'b1) begin
      bad++; $display("[TB] FAIL areset_frame got max=%0d idx=%0d cnt=%0d any=%0b want max=4 idx=0 cnt=1 any=1", out_max, out_idx, out_cnt, out_any);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_mask_skip();
    test_all_unmasked();
    test_backpressure();
    test_back_to_back();
    test_saturate_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
